// File: rtl/controle_somador_multibyte.sv
// Byte-serial multi-precision adder sequencer that time-shares one external 8-bit adder.
// Optional subtract mode is enabled by defining SOMADOR_SUB_EN (adds the `sub` port).
module controle_somador_multibyte #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef SOMADOR_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   soma,
  output logic                  cout,
  output logic [7:0]            add_x,
  output logic [7:0]            add_y,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_cout
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [8*NBYTES-1:0]   a_q, a_d;
  logic [8*NBYTES-1:0]   b_q, b_d;
  logic                  c_q, c_d;
  logic [8*NBYTES-1:0]   soma_q, soma_d;
  logic                  cout_q, cout_d;
  logic                  busy_q, done_q;
  logic                  accept_s;
  logic                  sub_in_s;
  logic                  sub_act_s;

`ifdef SOMADOR_SUB_EN
  logic                  sub_q;

  assign sub_in_s  = sub;
  assign sub_act_s = sub_q;

  // Subtract-mode flag, captured with the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (accept_s) begin
      sub_q <= sub;
    end else begin
      sub_q <= sub_q;
    end
  end
`else
  assign sub_in_s  = 1'b0;
  assign sub_act_s = 1'b0;
`endif

  // Start is honoured only when no operation is in flight
  assign accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    soma_d  = soma_q;
    cout_d  = cout_q;
    if (accept_s) begin
      state_d = ST_RUN;
      idx_d   = '0;
      a_d     = a;
      b_d     = b;
      c_d     = sub_in_s ? 1'b1 : cin;
      soma_d  = '0;
      cout_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          soma_d[8*idx_q +: 8] = add_s;
          c_d                  = add_cout;
          if (idx_q == LAST_IDX) begin
            cout_d  = add_cout;
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; busy/done are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      soma_q  <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      soma_q  <= soma_d;
      cout_q  <= cout_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // The shared adder sees operands only while running; otherwise it is parked at zero
  always_comb begin
    add_x   = 8'd0;
    add_y   = 8'd0;
    add_cin = 1'b0;
    if (state_q == ST_RUN) begin
      add_x   = a_q[8*idx_q +: 8];
      add_y   = b_q[8*idx_q +: 8] ^ {8{sub_act_s}};
      add_cin = c_q;
    end else begin
      add_x   = 8'd0;
      add_y   = 8'd0;
      add_cin = 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign soma = soma_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_controle_somador_multibyte.sv
// Self-checking bench: arithmetic reference model checked every cycle plus directed literal checks.
module tb_controle_somador_multibyte;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [31:0]     a, b;
  logic            cin;
  logic            sub;
  logic            busy, done, cout;
  logic [31:0]     soma;
  logic [7:0]      add_x, add_y, add_s;
  logic            add_cin, add_cout;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Shared external adder
  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};

  controle_somador_multibyte #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SOMADOR_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .soma(soma), .cout(cout),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle position of the current operation and its full arithmetic result
  int          m_cyc = 0;
  bit          m_have = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_c0 = 1'b0;
  logic [32:0] m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc  <= 0;
      m_have <= 1'b0;
      m_res  <= '0;
    end else if ((m_cyc == 0 || m_cyc == NB + 1) && start) begin
      m_cyc  <= 1;
      m_have <= 1'b1;
      m_a    <= a;
      m_b    <= sub ? ~b : b;
      m_c0   <= sub ? 1'b1 : cin;
      m_res  <= {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'd0, (sub ? 1'b1 : cin)};
    end else if (m_cyc == 0 || m_cyc == NB + 1) begin
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  function automatic logic [63:0] low_mask(input int j);
    return (64'd1 << (8 * j)) - 64'd1;
  endfunction

  // Carry entering byte j is bit 8j of the sum of the operand parts below byte j
  function automatic logic carry_into(input int j, input logic [31:0] x, input logic [31:0] y,
                                      input logic c0);
    logic [63:0] lo;
    lo = ({32'd0, x} & low_mask(j)) + ({32'd0, y} & low_mask(j)) + {63'd0, c0};
    return lo[8*j];
  endfunction

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit          run;
      int          j;
      logic [63:0] e_soma;
      run = (m_cyc >= 1) && (m_cyc <= NB);
      j   = run ? m_cyc - 1 : 0;
      e_soma = run ? ({32'd0, m_res[31:0]} & low_mask(j))
                   : (m_have ? {32'd0, m_res[31:0]} : 64'd0);
      chk("busy", {63'd0, busy}, {63'd0, run});
      chk("done", {63'd0, done}, {63'd0, (m_cyc == NB + 1)});
      chk("soma", {32'd0, soma}, e_soma);
      chk("cout", {63'd0, cout}, {63'd0, (!run && m_have) ? m_res[32] : 1'b0});
      chk("add_x", {56'd0, add_x}, run ? {56'd0, m_a[8*j +: 8]} : 64'd0);
      chk("add_y", {56'd0, add_y}, run ? {56'd0, m_b[8*j +: 8]} : 64'd0);
      chk("add_cin", {63'd0, add_cin}, run ? {63'd0, carry_into(j, m_a, m_b, m_c0)} : 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                        input logic vs);
    a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Watch n cycles; cycle 1 is the cycle right after the last edge
  task automatic observe(input int n, output int done_at, output int busy_n,
                         output int ndone, output logic [3:0] cin_seq);
    done_at = 0; busy_n = 0; ndone = 0; cin_seq = 4'd0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = i;
      end
      if (busy) busy_n++;
      if (i <= 4) cin_seq[i-1] = add_cin;
      tick();
    end
  endtask

  int          d_at, b_n, n_d, n_d2;
  logic [3:0]  cseq;

  initial begin
    rst = 1'b1; start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    #2;
    tick();
    @(negedge clk);
    chk("rst_soma", {32'd0, soma}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Basic add
    launch(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0);
    observe(8, d_at, b_n, n_d, cseq);
    chk("basic_done_at", 64'(d_at), 64'd5);
    chk("basic_busy_n", 64'(b_n), 64'd4);
    chk("basic_soma", {32'd0, soma}, 64'h0000_0101);
    chk("basic_cout", {63'd0, cout}, 64'd0);

    // Full carry ripple
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    observe(7, d_at, b_n, n_d, cseq);
    chk("ripple_cin_seq", {60'd0, cseq}, 64'hE);
    chk("ripple_soma", {32'd0, soma}, 64'h0);
    chk("ripple_cout", {63'd0, cout}, 64'd1);

    // Start during RUN is ignored
    launch(32'h0000_0008, 32'h0000_0001, 1'b1, 1'b0);
    observe(2, d_at, b_n, n_d, cseq);
    a = 32'h1111_1111; b = 32'h1111_1111; start = 1'b1;
    observe(1, d_at, b_n, n_d2, cseq);
    n_d = n_d + n_d2;
    start = 1'b0;
    observe(7, d_at, b_n, n_d2, cseq);
    n_d = n_d + n_d2;
    chk("ignore_ndone", 64'(n_d), 64'd1);
    chk("ignore_soma", {32'd0, soma}, 64'h0000_000A);
    chk("ignore_cout", {63'd0, cout}, 64'd0);

    // Back-to-back, then abort at idx=2
    a = 32'h0000_0001; b = 32'h0000_0002; cin = 1'b0; start = 1'b1;
    tick();
    a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1;
    observe(5, d_at, b_n, n_d, cseq);
    chk("b2b_done_at", 64'(d_at), 64'd5);
    start = 1'b0;
    observe(2, d_at, b_n, n_d, cseq);
    chk("b2b_busy_n", 64'(b_n), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_soma", {32'd0, soma}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    tick();
    observe(6, d_at, b_n, n_d, cseq);
    chk("abort_ndone", 64'(n_d), 64'd0);

`ifdef SOMADOR_SUB_EN
    launch(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    observe(7, d_at, b_n, n_d, cseq);
    chk("sub1_soma", {32'd0, soma}, 64'hFFFF_FFF0);
    chk("sub1_cout", {63'd0, cout}, 64'd0);
    launch(32'h0000_0020, 32'h0000_0010, 1'b0, 1'b1);
    observe(7, d_at, b_n, n_d, cseq);
    chk("sub2_soma", {32'd0, soma}, 64'h0000_0010);
    chk("sub2_cout", {63'd0, cout}, 64'd1);
    sub = 1'b0;
`endif

    // Extra mixed patterns, checked by the model
    launch(32'h1234_5678, 32'h89AB_CDEF, 1'b1, 1'b0);
    observe(6, d_at, b_n, n_d, cseq);
    chk("mix_soma", {32'd0, soma}, 64'h9BE0_2468);
    launch(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0);
    observe(6, d_at, b_n, n_d, cseq);
    chk("mix2_soma", {32'd0, soma}, 64'h0);
    chk("mix2_cout", {63'd0, cout}, 64'd1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controle_somador_multibyte.md
# controle_somador_multibyte

Multi-precision add sequencer that time-shares one external combinational 8-bit full adder (ports x, y, Cin → sum, Cout) to add two NBYTES-wide operands byte-serially, LSB byte first, carrying Cout into the next byte's Cin. Sits between the requesting logic and the shared adder instance. The parent wires this block's `add_*` ports to the adder.

## Interface
- NBYTES, 4, operand width in bytes; legal range 1–16.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  8*NBYTES  operand A, latched at accepted start.
- b  in  8*NBYTES  operand B, latched at accepted start.
- cin  in  1  carry into byte 0, latched at accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- soma  out  8*NBYTES  result; held until next accepted start.
- cout  out  1  carry out of top byte; held with soma.
- add_x  out  8  to adder x.
- add_y  out  8  to adder y.
- add_cin  out  1  to adder Cin.
- add_s  in  8  from adder sum.
- add_cout  in  1  from adder Cout.

## Operation
- States: IDLE, RUN, DONE. Byte index `idx`, width ceil(log2(NBYTES)), minimum 1 bit. Carry register `c`.
- IDLE:
  - On start=1: latch a, b, and cin into `c`.
  - Set idx=0, clear soma to 0, and go to RUN.
- RUN:
  - Combinationally drive add_x=a_reg[8*idx+:8], add_y=b_reg[8*idx+:8], add_cin=c.
  - Each edge: soma[8*idx+:8]←add_s, c←add_cout, idx←idx+1.
  - On the edge with idx=NBYTES-1: capture the final byte, set cout←add_cout, and go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - If start=1: accept as in IDLE and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- In IDLE and DONE: add_x=0, add_y=0, add_cin=0.
- start in RUN is ignored. Latched operands are not disturbed, and no extra done is produced.
- Arithmetic: soma = (a + b + cin) mod 2^(8*NBYTES); cout = bit 8*NBYTES of the full sum.
- NBYTES=1: RUN lasts one cycle; idx stays 0.

## Timing
- Reset values: state=IDLE, idx=0, c=0, soma=0, cout=0, busy=0, done=0, add_x=add_y=0, add_cin=0.
- rst has priority over everything. rst asserted during RUN or DONE gives IDLE with reset values on the following cycle; no done is produced for the aborted operation.
- Latency: start accepted at edge E0 → busy high in cycles after E0..E(NBYTES-1) → done high in the cycle after edge E(NBYTES).
- Throughput: one operation per NBYTES+1 cycles with back-to-back starts.
- The adder path is combinational within one cycle: a_reg/b_reg/c → adder → add_s/add_cout → soma/c registers. There is no registered adder stage.
- a, b, and cin may change freely after the accepting edge.
- soma and cout are stable from done until the edge after the next accepted start. During RUN, soma shows partially written bytes; the upper bytes read 0.

## Configuration
- SOMADOR_SUB_EN defined:
  - Adds input port `sub` (1 bit), latched at accepted start.
  - sub=1: add_y drives ~b_reg byte, initial c forced to 1 (cin ignored); soma = a − b mod 2^(8*NBYTES).
  - In sub mode, cout=1 means no borrow (a ≥ b unsigned).
  - sub=0: behaviour is identical to the non-macro build.
- SOMADOR_SUB_EN undefined: port `sub` does not exist; addition only.

## Test plan
All scenarios use NBYTES=4.
- Reset: rst=1 for 2 cycles with start=1, a=b=0xFFFFFFFF → all outputs 0, state IDLE, no done.
- Basic add: a=0x000000FF, b=0x00000001, cin=1 → done exactly 5 cycles after the start edge, soma=0x00000101, cout=0; busy high for exactly 4 cycles.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 → soma=0x00000000, cout=1. add_cin must read 0,1,1,1 across the four RUN cycles.
- Start during RUN: second start with a=b=0x11111111 asserted 2 cycles into the first op (a=0x00000008, b=0x00000001, cin=1) → single done, soma=0x0000000A, cout=0.
- Back-to-back and abort: start held high through DONE → second op begins with no IDLE cycle. Then assert rst at idx=2 → next cycle soma=0, busy=0, and no done appears.
- SOMADOR_SUB_EN: sub=1, a=0x00000010, b=0x00000020 → soma=0xFFFFFFF0, cout=0. Then sub=1, a=0x00000020, b=0x00000010 → soma=0x00000010, cout=1.
